// File: rtl/pll_hdmi_cfg_if.sv
// PLL reconfiguration management port; master drives write strobes, slave stalls via waitrequest.
// Write is held with stable address/data while waitrequest=1; no other backpressure path.
interface pll_hdmi_cfg_if;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest;

  modport master (
    output mgmt_address,
    output mgmt_write,
    output mgmt_writedata,
    input  mgmt_waitrequest
  );

  modport slave (
    input  mgmt_address,
    input  mgmt_write,
    input  mgmt_writedata,
    output mgmt_waitrequest
  );
endinterface

// File: rtl/pll_hdmi_cfg.sv
// HDMI PLL reconfig sequencer: 6 writes from T+1, GUARD mask, relock wait; each stalled write adds a cycle.
// Optional lock timeout with retries under `PLL_HDMI_CFG_TIMEOUT_EN; without it WAIT_LOCK waits forever.
module pll_hdmi_cfg #(
  parameter int TIMEOUT_W = 20,
  parameter int RETRIES   = 3,
  parameter int GUARD     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_req,
  input  logic [17:0]           cfg_n,
  input  logic [17:0]           cfg_m,
  input  logic [17:0]           cfg_c0,
  input  logic [31:0]           cfg_k,
  output logic                  cfg_busy,
  output logic                  cfg_done,
  output logic                  cfg_err,
  input  logic                  pll_locked,
  pll_hdmi_cfg_if.master        mgmt
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_MODE, S_WR_N, S_WR_M, S_WR_C0, S_WR_K, S_WR_START,
    S_GUARD, S_WAIT_LOCK, S_DONE, S_ERR
  } state_e;

  localparam int GW = (GUARD < 2) ? 1 : $clog2(GUARD);

  state_e        state_q, state_d;
  logic [GW-1:0] guard_q, guard_d;
  logic [1:0]    sync_q;
  logic [17:0]   n_q, m_q, c0_q;
  logic [31:0]   k_q;
  logic          accept;
  logic          locked_s;

  assign accept   = (state_q == S_IDLE) && cfg_req;
  assign locked_s = sync_q[1];

`ifdef PLL_HDMI_CFG_TIMEOUT_EN
  localparam int RW = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);

  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic [RW-1:0]        retry_q, retry_d;
  logic                 err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      retry_q <= '0;
      err_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      retry_q <= retry_d;
      err_q   <= err_d;
    end
  end

  assign cfg_err = err_q;
`else
  logic unused_timeout_params;
  assign unused_timeout_params = ^{TIMEOUT_W[0], RETRIES[0]};
  assign cfg_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      guard_q <= '0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      guard_q <= guard_d;
      sync_q  <= {sync_q[0], pll_locked};
    end
  end

  // Shadow copy keeps the sequence (and any retry) independent of later input changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q  <= '0;
      m_q  <= '0;
      c0_q <= '0;
      k_q  <= '0;
    end else if (accept) begin
      n_q  <= cfg_n;
      m_q  <= cfg_m;
      c0_q <= cfg_c0;
      k_q  <= cfg_k;
    end
  end

  always_comb begin
    state_d             = state_q;
    guard_d             = '0;
    mgmt.mgmt_write     = 1'b0;
    mgmt.mgmt_address   = 6'h00;
    mgmt.mgmt_writedata = 32'h0;
`ifdef PLL_HDMI_CFG_TIMEOUT_EN
    timer_d = '0;
    retry_d = accept ? '0 : retry_q;
    err_d   = accept ? 1'b0 : err_q;
`endif
    case (state_q)
      S_IDLE: if (cfg_req) state_d = S_WR_MODE;
      S_WR_MODE: begin
        mgmt.mgmt_write = 1'b1;
        if (!mgmt.mgmt_waitrequest) state_d = S_WR_N;
      end
      S_WR_N: begin
        mgmt.mgmt_write     = 1'b1;
        mgmt.mgmt_address   = 6'h03;
        mgmt.mgmt_writedata = {14'b0, n_q};
        if (!mgmt.mgmt_waitrequest) state_d = S_WR_M;
      end
      S_WR_M: begin
        mgmt.mgmt_write     = 1'b1;
        mgmt.mgmt_address   = 6'h04;
        mgmt.mgmt_writedata = {14'b0, m_q};
        if (!mgmt.mgmt_waitrequest) state_d = S_WR_C0;
      end
      S_WR_C0: begin
        mgmt.mgmt_write     = 1'b1;
        mgmt.mgmt_address   = 6'h05;
        mgmt.mgmt_writedata = {9'b0, 5'd0, c0_q};
        if (!mgmt.mgmt_waitrequest) state_d = S_WR_K;
      end
      S_WR_K: begin
        mgmt.mgmt_write     = 1'b1;
        mgmt.mgmt_address   = 6'h07;
        mgmt.mgmt_writedata = k_q;
        if (!mgmt.mgmt_waitrequest) state_d = S_WR_START;
      end
      S_WR_START: begin
        mgmt.mgmt_write     = 1'b1;
        mgmt.mgmt_address   = 6'h02;
        mgmt.mgmt_writedata = 32'h1;
        if (!mgmt.mgmt_waitrequest) state_d = S_GUARD;
      end
      S_GUARD: begin
        if (guard_q == GW'(GUARD - 1)) state_d = S_WAIT_LOCK;
        else                           guard_d = guard_q + 1'b1;
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = S_DONE;
`ifdef PLL_HDMI_CFG_TIMEOUT_EN
        end else if (&timer_q) begin
          if (retry_q < RW'(RETRIES)) begin
            retry_d = retry_q + 1'b1;
            state_d = S_WR_MODE;
          end else begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end else begin
          timer_d = timer_q + 1'b1;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cfg_busy = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
  assign cfg_done = (state_q == S_DONE);

endmodule

// File: tb/tb_pll_hdmi_cfg.sv
// Randomized bench for pll_hdmi_cfg: expected write list, write cycles and done cycle derived from the timing rules.
module tb_pll_hdmi_cfg;
  localparam int GUARD = 16;
  localparam int TW    = 4;
  localparam int RETR  = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_req;
  logic [17:0] cfg_n, cfg_m, cfg_c0;
  logic [31:0] cfg_k;
  logic        cfg_busy, cfg_done, cfg_err;
  logic        pll_locked;

  pll_hdmi_cfg_if mgmt_bus();

  pll_hdmi_cfg #(.TIMEOUT_W(TW), .RETRIES(RETR), .GUARD(GUARD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_req    (cfg_req),
    .cfg_n      (cfg_n),
    .cfg_m      (cfg_m),
    .cfg_c0     (cfg_c0),
    .cfg_k      (cfg_k),
    .cfg_busy   (cfg_busy),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .pll_locked (pll_locked),
    .mgmt       (mgmt_bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          c;
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t wr_q[$];
  int  done_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Bus monitor: logs completed writes and done pulses, and checks a stalled write holds steady.
  logic        stl_prev = 1'b0;
  logic [5:0]  stl_a;
  logic [31:0] stl_d;
  always @(negedge clk) begin
    if (!rst_n) begin
      stl_prev = 1'b0;
    end else begin
      if (stl_prev) begin
        chk("stall_write", mgmt_bus.mgmt_write, 1);
        chk("stall_addr", mgmt_bus.mgmt_address, stl_a);
        chk("stall_data", mgmt_bus.mgmt_writedata, stl_d);
      end
      if (mgmt_bus.mgmt_write && !mgmt_bus.mgmt_waitrequest)
        wr_q.push_back('{cyc, mgmt_bus.mgmt_address, mgmt_bus.mgmt_writedata});
      if (cfg_done) done_q.push_back(cyc);
      stl_prev = mgmt_bus.mgmt_write && mgmt_bus.mgmt_waitrequest;
      stl_a    = mgmt_bus.mgmt_address;
      stl_d    = mgmt_bus.mgmt_writedata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_writes(input string tag, input int base, input int attempt_gap, input int attempts,
                              input logic [17:0] n, input logic [17:0] m, input logic [17:0] c0,
                              input logic [31:0] k, input int s, input int len);
    logic [5:0]  ea [6];
    logic [31:0] ed [6];
    int          idx;
    ea = '{6'h00, 6'h03, 6'h04, 6'h05, 6'h07, 6'h02};
    ed = '{32'h0, {14'b0, n}, {14'b0, m}, {14'b0, c0}, k, 32'h1};
    chk({tag, "_nwrites"}, wr_q.size(), 6 * attempts);
    for (int t = 0; t < attempts; t++) begin
      for (int i = 0; i < 6; i++) begin
        idx = t * 6 + i;
        if (idx < wr_q.size()) begin
          chk({tag, "_wcyc"}, wr_q[idx].c, base + t * attempt_gap + i + ((i >= s) ? len : 0));
          chk({tag, "_waddr"}, wr_q[idx].a, ea[i]);
          chk({tag, "_wdata"}, wr_q[idx].d, ed[i]);
        end
      end
    end
  endtask

  // lk: cycle (relative to accept edge T) at which pll_locked rises; stale holds it high throughout.
  task automatic run_seq(input logic [17:0] n, input logic [17:0] m, input logic [17:0] c0,
                         input logic [31:0] k, input int s, input int len, input int lk,
                         input bit stale, input bit drop, input string tag);
    int a, wl, done_rel, wk;
    wr_q.delete();
    done_q.delete();
    pll_locked = stale;
    if (stale) repeat (3) step();
    cfg_n = n; cfg_m = m; cfg_c0 = c0; cfg_k = k;
    cfg_req = 1'b1;
    step();
    a       = cyc;
    cfg_req = 1'b0;
    wl       = 7 + len + GUARD;
    done_rel = (stale || (lk + 2 < wl)) ? wl + 1 : lk + 3;
    wk       = 5 + ((s < 4) ? len : 0);
    for (int r = 1; r <= 60; r++) begin
      mgmt_bus.mgmt_waitrequest = (r >= 1 + s) && (r <= s + len);
      pll_locked = stale || (r >= lk);
      if (r == 2) begin
        cfg_n = 18'($urandom); cfg_m = 18'($urandom); cfg_c0 = 18'($urandom); cfg_k = $urandom;
      end
      if (drop && r == wk) begin
        cfg_req = 1'b1;
        cfg_n = ~n; cfg_m = ~m; cfg_c0 = ~c0; cfg_k = ~k;
      end
      if (drop && r == wk + 1) cfg_req = 1'b0;
      #1;
      if (r == 1) begin
        chk({tag, "_busy_start"}, cfg_busy, 1);
        chk({tag, "_err_cleared"}, cfg_err, 0);
      end
      if (r == done_rel - 1) chk({tag, "_busy_pre_done"}, cfg_busy, 1);
      if (r == done_rel)     chk({tag, "_busy_at_done"}, cfg_busy, 0);
      step();
    end
    mgmt_bus.mgmt_waitrequest = 1'b0;
    pll_locked = 1'b0;
    repeat (4) step();
    check_writes(tag, a, 0, 1, n, m, c0, k, s, len);
    chk({tag, "_ndone"}, done_q.size(), 1);
    if (done_q.size() >= 1) chk({tag, "_done_cyc"}, done_q[0], a + done_rel - 1);
  endtask

  initial begin
    int a;
    logic [17:0] rn, rm, rc;
    logic [31:0] rk;

    rst_n = 1'b0; cfg_req = 1'b0; cfg_n = '0; cfg_m = '0; cfg_c0 = '0; cfg_k = '0;
    pll_locked = 1'b0; mgmt_bus.mgmt_waitrequest = 1'b0;
    #1;
    chk("rst_busy", cfg_busy, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_write", mgmt_bus.mgmt_write, 0);
    chk("rst_addr", mgmt_bus.mgmt_address, 0);
    chk("rst_data", mgmt_bus.mgmt_writedata, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    run_seq(18'h10000, 18'h00404, 18'h20201, 32'hE8F5C28F, 6, 0, 30, 1'b0, 1'b0, "zero_wait");
    run_seq(18'h10000, 18'h00404, 18'h20201, 32'hE8F5C28F, 2, 3, 30, 1'b0, 1'b0, "stall_m");
    run_seq(18'($urandom), 18'($urandom), 18'($urandom), $urandom, 6, 0, 0, 1'b1, 1'b0, "stale");
    run_seq(18'($urandom), 18'($urandom), 18'($urandom), $urandom, 6, 0, 10, 1'b0, 1'b1, "drop");
    for (int i = 0; i < 8; i++) begin
      run_seq(18'($urandom), 18'($urandom), 18'($urandom), $urandom,
              int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), int'($urandom_range(1, 40)),
              $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), "rand");
    end

`ifdef PLL_HDMI_CFG_TIMEOUT_EN
    // Each attempt: 6 writes + GUARD + 2^TW lock-wait cycles; ERR follows the last attempt.
    wr_q.delete();
    done_q.delete();
    rn = 18'($urandom); rm = 18'($urandom); rc = 18'($urandom); rk = $urandom;
    cfg_n = rn; cfg_m = rm; cfg_c0 = rc; cfg_k = rk; cfg_req = 1'b1;
    step();
    a = cyc;
    cfg_req = 1'b0;
    for (int r = 1; r <= 90; r++) begin
      #1;
      if (r == (RETR + 1) * (6 + GUARD + (1 << TW)))     chk("to_err_before", cfg_err, 0);
      if (r == (RETR + 1) * (6 + GUARD + (1 << TW)) + 1) chk("to_err_set", cfg_err, 1);
      step();
    end
    check_writes("timeout", a, 6 + GUARD + (1 << TW), RETR + 1, rn, rm, rc, rk, 6, 0);
    chk("to_ndone", done_q.size(), 0);
    chk("to_err_sticky", cfg_err, 1);
    run_seq(18'($urandom), 18'($urandom), 18'($urandom), $urandom, 6, 0, 5, 1'b0, 1'b0, "after_err");
`endif

    // Reset during WR_C0, then no writes without a fresh request.
    cfg_n = 18'h1234; cfg_m = 18'h0404; cfg_c0 = 18'h0303; cfg_k = 32'h5; cfg_req = 1'b1;
    step();
    cfg_req = 1'b0;
    repeat (3) step();
    #1;
    chk("rstmid_in_c0", mgmt_bus.mgmt_address, 6'h05);
    rst_n = 1'b0;
    #1;
    chk("rstmid_write", mgmt_bus.mgmt_write, 0);
    chk("rstmid_addr", mgmt_bus.mgmt_address, 0);
    chk("rstmid_data", mgmt_bus.mgmt_writedata, 0);
    chk("rstmid_busy", cfg_busy, 0);
    chk("rstmid_done", cfg_done, 0);
    chk("rstmid_err", cfg_err, 0);
    repeat (2) step();
    rst_n = 1'b1;
    wr_q.delete();
    done_q.delete();
    repeat (30) step();
    chk("rstmid_no_writes", wr_q.size(), 0);
    chk("rstmid_no_done", done_q.size(), 0);
    chk("rstmid_idle", cfg_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pll_hdmi_cfg.md
# pll_hdmi_cfg

Reconfiguration controller for the HDMI pixel-clock PLL. It accepts a complete counter set (N, M, C0, fractional K) from the video-mode logic. It then sequences the writes into the PLL reconfiguration management port, issues the start command and waits for the PLL to relock. It sits between the scaler/video-mode registers and the reconfigurable `pll_hdmi` instance, and is the only master on that port.

## Interface
- `TIMEOUT_W`, 20: width of the lock-wait counter. 2^20 cycles is about 21 ms at 50 MHz.
- `RETRIES`, 3: number of full reprogram attempts after the first one fails. Used only with the timeout feature.
- `GUARD`, 16: number of cycles after start during which `pll_locked` is ignored.
- `clk`  in  1  management clock, the same 50 MHz reference that feeds the PLL.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_req`  in  1  request to reprogram. Sampled only in IDLE.
- `cfg_n`, `cfg_m`, `cfg_c0`  in  18 each  bits `{odd_en[17], bypass[16], hi[15:8], lo[7:0]}`.
- `cfg_k`  in  32  fractional divider value.
- `cfg_busy`  out  1  a sequence is in progress.
- `cfg_done`  out  1  one-cycle pulse when the PLL has relocked.
- `cfg_err`  out  1  sticky flag: lock was not achieved.
- `mgmt_address`  out  6  management address.
- `mgmt_write`  out  1  management write strobe.
- `mgmt_writedata`  out  32  management write data.
- `mgmt_waitrequest`  in  1  slave stall.
- `pll_locked`  in  1  PLL `locked` output. Asynchronous to `clk`, so it is passed through a 2-flop synchronizer before use.

## Operation
- States, in order: IDLE, WR_MODE, WR_N, WR_M, WR_C0, WR_K, WR_START, GUARD, WAIT_LOCK, DONE, ERR.
- **IDLE:** if `cfg_req`=1, latch `cfg_n/m/c0/k` into shadow registers and go to WR_MODE. Inputs are not sampled again until the next IDLE.
- **Write sequence** (address / data):
  - WR_MODE: 0x00 / 0 (waitrequest mode).
  - WR_N: 0x03 / `{14'b0, n}`.
  - WR_M: 0x04 / `{14'b0, m}`.
  - WR_C0: 0x05 / `{9'b0, 5'd0 (counter select), c0}`.
  - WR_K: 0x07 / `k`.
  - WR_START: 0x02 / 1.
- **Write handshake:**
  - `mgmt_write`=1 with address and data held stable while `mgmt_waitrequest`=1.
  - The transfer completes on the edge where `mgmt_waitrequest`=0; the FSM advances on that edge.
  - `mgmt_write` never deasserts while a transfer is stalled.
- **GUARD:** count `GUARD` cycles, then go to WAIT_LOCK. This masks the stale `locked` level from before reconfiguration.
- **WAIT_LOCK:** synchronized `pll_locked`=1 → DONE.
- **DONE:** lasts one cycle, then IDLE.
- **ERR:** lasts one cycle, then IDLE.
- **`cfg_err`:** set on entry to ERR. Cleared when the next `cfg_req` is accepted.
- **Requests while busy:** `cfg_req` in any state other than IDLE is ignored and not queued.
- **Reset:** asynchronous assertion mid-sequence returns the FSM to IDLE immediately and clears all outputs. A half-written PLL is not repaired; the requester must request again.

## Timing
- **Reset values:** `cfg_busy`=0, `cfg_done`=0, `cfg_err`=0, `mgmt_write`=0, `mgmt_address`=0, `mgmt_writedata`=0.
- **Request to first write:** `cfg_req` is accepted at edge T. `cfg_busy`=1 and `mgmt_write`=1 (WR_MODE) from T+1.
- **Write phase:** with `mgmt_waitrequest` tied 0, the six writes occupy T+1..T+6 and GUARD starts at T+7. Each stalled cycle adds exactly one cycle.
- **Lock to done:** `pll_locked` rises. Two synchronizer cycles later WAIT_LOCK sees it. `cfg_done`=1 for the following cycle, and `cfg_busy`=0 in that same cycle.
- **Outside write states:** `mgmt_write`=0 in every non-write state.

## Configuration
- **`PLL_HDMI_CFG_TIMEOUT_EN` defined:**
  - A `TIMEOUT_W`-bit counter runs in WAIT_LOCK. When it reaches all-ones, the attempt fails.
  - On failure, if retries used < `RETRIES`: increment the retry count, clear the timer and go to WR_MODE, rewriting from the shadow registers.
  - Otherwise go to ERR.
  - The retry count is cleared on accept.
- **Not defined:**
  - WAIT_LOCK waits indefinitely.
  - ERR is unreachable and `cfg_err` is constant 0.
  - No timer logic is synthesized.

## Test plan
- **Zero-wait sequence:** `waitrequest`=0, request N=0x10000, M=0x00404, C0=0x20201, K=0xE8F5C28F → six writes at 0x00, 0x03, 0x04, 0x05, 0x07, 0x02 with the exact data above on T+1..T+6. Assert `locked` at T+30 → `cfg_done` at T+33, `busy` low.
- **Stall handling:** hold `waitrequest`=1 for 3 cycles during WR_M → address 0x04 and its data stay stable for 4 cycles with `mgmt_write`=1, and every later write is delayed by exactly 3 cycles.
- **Stale lock masked:** `locked` held 1 throughout → no `cfg_done` before GUARD expires. `cfg_done` then occurs exactly once.
- **Busy request dropped:** second `cfg_req` during WR_K with different values → ignored. The first values are written and a single `cfg_done` is produced.
- **Timeout and retries (macro on, `TIMEOUT_W`=4, `RETRIES`=1):** `locked` stays 0 → the write sequence repeats twice, then `cfg_err`=1. A new `cfg_req` clears `cfg_err`.
- **Reset mid-sequence:** `rst_n` low during WR_C0 → all outputs 0 asynchronously. After release, the FSM is in IDLE and issues no writes without a new `cfg_req`.
